modexp_streamer: RTL and testbench

MODEXP_STREAMER -- requirements
Module: modexp_streamer

---
 rtl/modexp_streamer_pkg.sv | 19 +
 rtl/modexp_streamer_word_mux.sv | 28 ++
 rtl/modexp_streamer.sv | 187 ++++++++++++++++++
 tb/tb_modexp_streamer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_streamer_pkg.sv
// Shared definitions for the ModExp operand streamer: default word width,
// controller state encodings and the ModExp engine state codes it watches.
package modexp_streamer_pkg;

   localparam int MODEXP_DATA_WIDTH = 64;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEND   = 3'd1,
      S_WAIT   = 3'd2,
      S_READ   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   // ModExp engine exp_state codes
   localparam logic [4:0] EXP_COMPLETE      = 5'd9;
   localparam logic [4:0] EXP_OUTPUT_RESULT = 5'd10;

endpackage

// File: rtl/modexp_streamer_word_mux.sv
// word_mux: picks DATA_WIDTH-bit word i_sel out of a WIDTH-bit vector, word 0
// being the least significant. Selects past the last word read as zero.
module word_mux
   import modexp_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = MODEXP_DATA_WIDTH,
   parameter int WIDTH      = 4096,
   parameter int WORDS      = WIDTH / DATA_WIDTH,
   parameter int SEL_W      = $clog2(WORDS) + 1
) (
   input  logic [WIDTH-1:0]      i_vec,
   input  logic [SEL_W-1:0]      i_sel,
   output logic [DATA_WIDTH-1:0] o_word
);

   // Word selection by index compare
   always_comb begin
      // NOTE: the default assignment first means every path drives o_word,
      // so this stays pure combinational logic and no latch is inferred.
      o_word = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (i_sel == SEL_W'(k)) begin
            o_word = i_vec[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/modexp_streamer.sv
// modexp_streamer: captures WIDTH-bit operands on go, streams them LSW first
// to a word-serial ModExp engine, waits (bounded) for COMPLETE, then collects
// the result words into cypher and pulses done.
module modexp_streamer
   import modexp_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = MODEXP_DATA_WIDTH,
   parameter int WIDTH      = 4096,
   parameter int WORDS      = WIDTH / DATA_WIDTH,
   parameter int TIMEOUT    = 2 ** 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic [WIDTH-1:0]      message,
   input  logic [WIDTH-1:0]      exponent,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [WIDTH-1:0]      r,
   input  logic [WIDTH-1:0]      t,
   input  logic [63:0]           nprime0_in,
   input  logic [4:0]            exp_state,
   input  logic [DATA_WIDTH-1:0] res_out,
   output logic [DATA_WIDTH-1:0] m_buf,
   output logic [DATA_WIDTH-1:0] e_buf,
   output logic [DATA_WIDTH-1:0] n_buf,
   output logic [DATA_WIDTH-1:0] r_buf,
   output logic [DATA_WIDTH-1:0] t_buf,
   output logic [63:0]           nprime0,
   output logic                  startInput,
   output logic                  startCompute,
   output logic                  getResult,
   output logic [WIDTH-1:0]      cypher,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CNT_W = $clog2(WORDS) + 1;
   localparam int TO_W  = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_count;
   logic [TO_W-1:0]         r_timeout;
   logic [WIDTH-1:0]        r_message, r_exponent, r_modulus, r_r, r_t;
   logic [63:0]             r_nprime0;
   logic [DATA_WIDTH-1:0]   r_m_buf, r_e_buf, r_n_buf, r_r_buf, r_t_buf;
   logic [WIDTH-1:0]        r_cypher;
   logic                    r_start_input, r_start_compute, r_get_result;
   logic                    r_busy, r_done, r_error;

   logic [DATA_WIDTH-1:0]   w_m_word, w_e_word, w_n_word, w_r_word, w_t_word;

   word_mux #(.DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(CNT_W))
      u_mux_m (.i_vec(r_message),  .i_sel(r_count), .o_word(w_m_word));
   word_mux #(.DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(CNT_W))
      u_mux_e (.i_vec(r_exponent), .i_sel(r_count), .o_word(w_e_word));
   word_mux #(.DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(CNT_W))
      u_mux_n (.i_vec(r_modulus),  .i_sel(r_count), .o_word(w_n_word));
   word_mux #(.DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(CNT_W))
      u_mux_r (.i_vec(r_r),        .i_sel(r_count), .o_word(w_r_word));
   word_mux #(.DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(CNT_W))
      u_mux_t (.i_vec(r_t),        .i_sel(r_count), .o_word(w_t_word));

   // Controller: capture, stream operands, bounded wait, collect result, finish
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every register here, wide operand and result stores included,
      // takes the asynchronous reset so a mid-run reset leaves no stale data.
      if (reset) begin
         r_state         <= S_IDLE;
         r_count         <= '0;
         r_timeout       <= '0;
         r_message       <= '0;
         r_exponent      <= '0;
         r_modulus       <= '0;
         r_r             <= '0;
         r_t             <= '0;
         r_nprime0       <= '0;
         r_m_buf         <= '0;
         r_e_buf         <= '0;
         r_n_buf         <= '0;
         r_r_buf         <= '0;
         r_t_buf         <= '0;
         r_cypher        <= '0;
         r_start_input   <= 1'b0;
         r_start_compute <= 1'b0;
         r_get_result    <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_error         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every read in this block
         // sees the pre-edge value regardless of statement order.
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_message       <= message;
                  r_exponent      <= exponent;
                  r_modulus       <= modulus;
                  r_r             <= r;
                  r_t             <= t;
                  r_nprime0       <= nprime0_in;
                  r_count         <= '0;
                  r_start_input   <= 1'b1;
                  r_start_compute <= 1'b1;
                  r_busy          <= 1'b1;
                  r_state         <= S_SEND;
               end
            end
            S_SEND: begin
               r_m_buf <= w_m_word;
               r_e_buf <= w_e_word;
               r_n_buf <= w_n_word;
               r_r_buf <= w_r_word;
               r_t_buf <= w_t_word;
               if (r_count == LAST_WORD) begin
                  r_count       <= '0;
                  r_timeout     <= '0;
                  r_start_input <= 1'b0;
                  r_get_result  <= 1'b1;
                  r_state       <= S_WAIT;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            S_WAIT: begin
               // COMPLETE wins over a timeout landing in the same cycle
               if (exp_state == EXP_COMPLETE) begin
                  r_count <= '0;
                  r_state <= S_READ;
               end else if (r_timeout == TO_LAST) begin
                  r_error         <= 1'b1;
                  r_start_input   <= 1'b0;
                  r_start_compute <= 1'b0;
                  r_get_result    <= 1'b0;
                  r_busy          <= 1'b0;
                  r_state         <= S_IDLE;
               end else begin
                  r_timeout <= r_timeout + TO_W'(1);
               end
            end
            S_READ: begin
               for (int k = 0; k < WORDS; k++) begin
                  if (r_count == CNT_W'(k)) begin
                     r_cypher[k*DATA_WIDTH +: DATA_WIDTH] <= res_out;
                  end
               end
               if (r_count == LAST_WORD) begin
                  r_count         <= '0;
                  r_start_compute <= 1'b0;
                  r_get_result    <= 1'b0;
                  r_done          <= 1'b1;
                  r_state         <= S_FINISH;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_buf        = r_m_buf;
   assign e_buf        = r_e_buf;
   assign n_buf        = r_n_buf;
   assign r_buf        = r_r_buf;
   assign t_buf        = r_t_buf;
   assign nprime0      = r_nprime0;
   assign startInput   = r_start_input;
   assign startCompute = r_start_compute;
   assign getResult    = r_get_result;
   assign cypher       = r_cypher;
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;

endmodule

// File: tb/tb_modexp_streamer.sv
// Testbench for modexp_streamer: a behavioural ModExp engine answers
// getResult; expected stream words and results are queued at launch and
// compared when the DUT produces them. A second instance with TIMEOUT=16
// runs in lockstep for the timeout case.
module tb_modexp_streamer;
   import modexp_streamer_pkg::*;

   localparam int DW    = 64;
   localparam int W     = 4096;
   localparam int WORDS = W / DW;
   localparam int TO_SHORT = 16;

   typedef struct packed {
      logic [DW-1:0] m, e, n, r, t;
   } words_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          go;
   logic [W-1:0]  message, exponent, modulus, r, t;
   logic [63:0]   nprime0_in;
   logic [4:0]    exp_state;
   logic [DW-1:0] res_out;

   logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf;
   logic [63:0]   nprime0;
   logic          startInput, startCompute, getResult, busy, done, error;
   logic [W-1:0]  cypher;

   logic [DW-1:0] m_buf_to, e_buf_to, n_buf_to, r_buf_to, t_buf_to;
   logic [63:0]   nprime0_to;
   logic          startInput_to, startCompute_to, getResult_to, busy_to, done_to, error_to;
   logic [W-1:0]  cypher_to;

   int n_vec  = 0;
   int n_miss = 0;

   words_t       sq[$];
   logic [W-1:0] cy_q[$];

   // behavioural engine controls
   bit           model_en = 1'b1;
   bit           force_complete = 1'b0;
   int           model_delay = 1;
   logic [W-1:0] model_result = '0;
   int           gr_cnt = 0;
   int           rd_idx = 0;
   bit           reading = 1'b0;

   always #5 clk = ~clk;

   modexp_streamer #(.DATA_WIDTH(DW), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .go(go),
      .message(message), .exponent(exponent), .modulus(modulus), .r(r), .t(t),
      .nprime0_in(nprime0_in), .exp_state(exp_state), .res_out(res_out),
      .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
      .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
      .getResult(getResult), .cypher(cypher), .busy(busy), .done(done), .error(error)
   );

   modexp_streamer #(.DATA_WIDTH(DW), .WIDTH(W), .TIMEOUT(TO_SHORT)) dut_to (
      .clk(clk), .reset(reset), .go(go),
      .message(message), .exponent(exponent), .modulus(modulus), .r(r), .t(t),
      .nprime0_in(nprime0_in), .exp_state(exp_state), .res_out(res_out),
      .m_buf(m_buf_to), .e_buf(e_buf_to), .n_buf(n_buf_to), .r_buf(r_buf_to), .t_buf(t_buf_to),
      .nprime0(nprime0_to), .startInput(startInput_to), .startCompute(startCompute_to),
      .getResult(getResult_to), .cypher(cypher_to), .busy(busy_to), .done(done_to), .error(error_to)
   );

   // Engine model: COMPLETE model_delay cycles after getResult rises, then
   // one result word per cycle while reporting OUTPUT_RESULT.
   always @(negedge clk) begin
      if (force_complete) begin
         exp_state = EXP_COMPLETE;
      end else if (model_en && getResult) begin
         if (reading) begin
            res_out   = model_result[rd_idx*DW +: DW];
            rd_idx    = rd_idx + 1;
            exp_state = EXP_OUTPUT_RESULT;
         end else begin
            gr_cnt = gr_cnt + 1;
            if (gr_cnt >= model_delay) begin
               exp_state = EXP_COMPLETE;
               reading   = 1'b1;
            end
         end
      end else begin
         gr_cnt    = 0;
         rd_idx    = 0;
         reading   = 1'b0;
         exp_state = 5'd0;
         res_out   = '0;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      int k;
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         k = 0;
         while (k < WORDS - 1 && obs[k*DW +: DW] === exp[k*DW +: DW]) k++;
         $error("FAIL %s: word %0d observed %h expected %h", tag, k, obs[k*DW +: DW], exp[k*DW +: DW]);
      end
   endtask

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   // Drive operands and go (we sit at a negedge); returns at the negedge
   // after the accepting edge, which the monitor calls cycle 0.
   task automatic launch(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                         input logic [W-1:0] rr, input logic [W-1:0] tt, input logic [63:0] np,
                         input logic [W-1:0] res, input int delay, input bit expect_done);
      words_t wv;
      message = m; exponent = e; modulus = n; r = rr; t = tt; nprime0_in = np;
      model_result = res;
      model_delay  = delay;
      for (int k = 0; k < WORDS; k++) begin
         wv = '{m: m[k*DW +: DW], e: e[k*DW +: DW], n: n[k*DW +: DW], r: rr[k*DW +: DW], t: tt[k*DW +: DW]};
         sq.push_back(wv);
      end
      if (expect_done) cy_q.push_back(res);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Follow one run until done has pulsed and busy has dropped. done is
   // expected to be high in the FINISH cycle: the go edge, WORDS SEND cycles,
   // delay WAIT cycles and WORDS READ cycles put it 2*WORDS+delay cycles
   // after cycle 0.
   task automatic monitor(input int delay, input int go_pulse_at, input int hold_go_at,
                          input int force_until, input logic [63:0] np_exp);
      int cyc = 0, done_cnt = 0, done_cyc = -1, si_cnt = 0, err_cnt = 0;
      bit finished = 1'b0;
      words_t wv;
      logic [W-1:0] exp_cy = 'x;
      while (!finished && cyc < 2 * WORDS + delay + 50) begin
         if (cyc == 0) begin
            check("go_accepted_busy", busy, 1'b1);
            message = rand_vec(); exponent = rand_vec(); modulus = rand_vec();
            r = rand_vec(); t = rand_vec(); nprime0_in = {$urandom(), $urandom()};
         end
         if (force_until > 0) force_complete = (cyc < force_until);
         if (cyc == go_pulse_at) begin
            message = rand_vec();
            go = 1'b1;
         end else if (cyc == go_pulse_at + 1) begin
            go = 1'b0;
         end
         if (cyc == hold_go_at) go = 1'b1;
         if (startInput) si_cnt++;
         if (cyc >= 1 && cyc <= WORDS) begin
            if (sq.size() > 0) wv = sq.pop_front(); else wv = 'x;
            check($sformatf("stream_word_%0d", cyc - 1), {m_buf, e_buf, n_buf, r_buf, t_buf}, wv);
         end
         if (error) err_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               if (cy_q.size() > 0) exp_cy = cy_q.pop_front();
               check("cypher_at_done", cypher, exp_cy);
            end
         end
         if (done_cyc >= 0 && !busy) begin
            finished = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("run_finished", finished, 1'b1);
      check("done_pulses", done_cnt, 1);
      check("go_to_done_latency", done_cyc, 2 * WORDS + delay);
      check("startInput_cycles", si_cnt, WORDS);
      check("error_pulses", err_cnt, 0);
      check("nprime0", nprime0, np_exp);
      check("levels_dropped", {startInput, startCompute, getResult}, 3'b000);
      check("cypher_held", cypher, exp_cy);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bufs"}, {m_buf, e_buf, n_buf, r_buf, t_buf, nprime0}, '0);
      check({tag, "_ctrl"}, {startInput, startCompute, getResult, busy, done, error}, '0);
      check({tag, "_cypher"}, cypher, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] m, e, n, rr, tt, res, seq_vec, prev_res;
      int err_cyc, err_pulses, done_to_cnt;

      reset = 1'b1; go = 1'b0;
      message = '0; exponent = '0; modulus = '0; r = '0; t = '0; nprime0_in = '0;
      repeat (2) @(negedge clk);

      // reset state of both instances
      check_all_zero("reset_state");
      check("reset_state_to_bufs", {m_buf_to, e_buf_to, n_buf_to, r_buf_to, t_buf_to, nprime0_to}, '0);
      check("reset_state_to_ctrl", {startInput_to, startCompute_to, getResult_to, busy_to, done_to, error_to}, '0);
      check("reset_state_to_cypher", cypher_to, '0);
      reset = 1'b0;

      // basic run: 8^13 mod 77, engine answers 50 after 100 cycles
      rr = rand_vec(); tt = rand_vec();
      launch(W'(8), W'(13), W'(77), rr, tt, 64'h0123_4567_89ab_cdef, W'(50), 100, 1'b1);
      monitor(100, -10, -10, 0, 64'h0123_4567_89ab_cdef);

      // streaming order: word k of every operand is k+1
      for (int k = 0; k < WORDS; k++) seq_vec[k*DW +: DW] = DW'(k + 1);
      res = rand_vec();
      launch(seq_vec, seq_vec, seq_vec, seq_vec, seq_vec, 64'h1, res, 5, 1'b1);
      monitor(5, -10, -10, 0, 64'h1);

      // go pulsed in SEND and in READ, then held through FINISH
      m = rand_vec(); e = rand_vec(); n = rand_vec(); res = rand_vec();
      launch(m, e, n, m, e, 64'hfeed_f00d_0000_0001, res, 6, 1'b1);
      monitor(6, 10, 2 * WORDS + 6 - 1, 0, 64'hfeed_f00d_0000_0001);
      check("go_held_idle_cycle", {busy, go}, 2'b01);
      res = rand_vec();
      launch(n, m, e, n, m, 64'h2, res, 3, 1'b1);
      monitor(3, WORDS + 3 + 10, -10, 0, 64'h2);

      // early COMPLETE from IDLE through most of SEND is ignored
      m = rand_vec(); res = rand_vec();
      force_complete = 1'b1;
      launch(m, m, m, m, m, 64'h3, res, 4, 1'b1);
      monitor(4, -10, -10, 40, 64'h3);
      force_complete = 1'b0;

      // reset asserted mid-SEND, outputs clear before the next edge
      m = rand_vec();
      launch(m, m, m, m, m, 64'h4, rand_vec(), 5, 1'b0);
      repeat (20) @(negedge clk);
      check("mid_run_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1 check_all_zero("reset_async");
      sq.delete();
      @(negedge clk);
      reset = 1'b0;
      m = rand_vec(); e = rand_vec(); prev_res = rand_vec();
      launch(m, e, m, e, m, 64'h5, prev_res, 7, 1'b1);
      monitor(7, -10, -10, 0, 64'h5);
      check("to_inst_prior_result", cypher_to, prev_res);

      // timeout: engine never completes; TIMEOUT=16 instance must error out
      model_en = 1'b0;
      launch(rand_vec(), rand_vec(), rand_vec(), rand_vec(), rand_vec(), 64'h6, rand_vec(), 1, 1'b0);
      err_cyc = -1; err_pulses = 0; done_to_cnt = 0;
      for (int c = 0; c < WORDS + TO_SHORT + 24; c++) begin
         if (error_to) begin
            err_pulses++;
            if (err_cyc < 0) begin
               err_cyc = c;
               check("timeout_idle", busy_to, 1'b0);
               check("timeout_levels", {startInput_to, startCompute_to, getResult_to}, 3'b000);
               check("timeout_no_done", done_to, 1'b0);
            end
         end
         if (done_to) done_to_cnt++;
         @(negedge clk);
      end
      check("timeout_error_cycle", err_cyc, WORDS + TO_SHORT);
      check("timeout_error_pulses", err_pulses, 1);
      check("timeout_done_count", done_to_cnt, 0);
      check("timeout_cypher_kept", cypher_to, prev_res);
      check("long_timeout_still_waiting", {busy, getResult, error}, 3'b110);
      sq.delete();
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("final_reset");
      reset = 1'b0;
      model_en = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
